// File: rtl/fsm_seq_generator.sv
// fsm_seq_generator: serial bit-pattern transmitter feeding the sequence-detector FSMs.
// Latches pattern/length/repeat count on start, shifts the pattern out MSB-first
// with a qualifying valid, and ends each frame with a one-cycle done pulse.
// Optional feature macro: SEQ_GEN_GAP_EN inserts one idle (valid=0) cycle between repetitions.
module fsm_seq_generator #(
  parameter int PAT_W = 8,
  localparam int LW = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    pat_len,
  input  logic [3:0]       reps,
  output logic             data_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state_q, state_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [3:0]       rep_q, rep_d;
  logic [LW-1:0]    bitcnt_q, bitcnt_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LW-1:0]    eff_len;

  // Pick one pattern bit by shifting, so the index width never has to match PAT_W exactly
  function automatic logic sel_bit(input logic [PAT_W-1:0] pat, input logic [LW-1:0] idx);
    logic [PAT_W-1:0] shifted;
    shifted = pat >> idx;
    return shifted[0];
  endfunction

  // Lengths beyond the pattern register are clamped to the full width
  assign eff_len = (pat_len > LW'(PAT_W)) ? LW'(PAT_W) : pat_len;

  // State, latched request and output registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      bitcnt_q <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      rep_q    <= rep_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state plus the output values that belong to that next state, so outputs come straight from flops
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    rep_d    = rep_q;
    bitcnt_d = bitcnt_q;
    data_d   = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (eff_len != '0)) begin
          state_d  = SHIFT;
          pat_d    = pattern;
          len_d    = eff_len;
          rep_d    = reps;
          bitcnt_d = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          data_d   = sel_bit(pattern, eff_len - LW'(1));
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (bitcnt_q == len_q - LW'(1)) begin
          if (rep_q == 4'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rep_d    = rep_q - 4'd1;
            bitcnt_d = '0;
`ifdef SEQ_GEN_GAP_EN
            state_d  = GAP;
`else
            valid_d  = 1'b1;
            data_d   = sel_bit(pat_q, len_q - LW'(1));
`endif
          end
        end else begin
          bitcnt_d = bitcnt_q + LW'(1);
          valid_d  = 1'b1;
          data_d   = sel_bit(pat_q, len_q - LW'(2) - bitcnt_q);
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        state_d = SHIFT;
        busy_d  = 1'b1;
        valid_d = 1'b1;
        data_d  = sel_bit(pat_q, len_q - LW'(1));
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fsm_seq_generator.sv
// tb_fsm_seq_generator: directed self-checking bench for fsm_seq_generator.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_fsm_seq_generator;

  localparam int PAT_W = 8;
  localparam int LW = $clog2(PAT_W + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LW-1:0]    pat_len;
  logic [3:0]       reps;
  logic             data_out;
  logic             valid;
  logic             busy;
  logic             done;

  int checks;
  int fails;

  fsm_seq_generator #(.PAT_W(PAT_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pattern(pattern),
    .pat_len(pat_len),
    .reps(reps),
    .data_out(data_out),
    .valid(valid),
    .busy(busy),
    .done(done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one start request for a single edge; returns when the first bit is visible
  task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [LW-1:0] len, input logic [3:0] rp);
    pattern = pat;
    pat_len = len;
    reps    = rp;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Expected per-cycle {busy,valid,data_out,done} for a whole frame; collects the observed stream
  task automatic checkFrame(input string tag, input logic [15:0] pat, input int len, input int rp,
                            output logic [31:0] stream, output int nbits);
    stream = '0;
    nbits  = 0;
    for (int r = 0; r <= rp; r++) begin
      for (int i = len - 1; i >= 0; i--) begin
        checkOutput({tag, " bit"}, 32'({busy, valid, data_out, done}), 32'({1'b1, 1'b1, pat[i], 1'b0}));
        if (valid) begin
          stream = {stream[30:0], data_out};
          nbits++;
        end
        @(negedge clk);
      end
`ifdef SEQ_GEN_GAP_EN
      if (r < rp) begin
        checkOutput({tag, " gap"}, 32'({busy, valid, data_out, done}), 32'(4'b1000));
        @(negedge clk);
      end
`endif
    end
    checkOutput({tag, " done"}, 32'({busy, valid, data_out, done}), 32'(4'b1001));
    @(negedge clk);
    checkOutput({tag, " idle"}, 32'({busy, valid, data_out, done}), 32'(4'b0000));
  endtask

  // Number of 110 occurrences a downstream detector would flag in the stream
  function automatic int count110(input logic [31:0] stream, input int nbits);
    int cnt = 0;
    for (int i = 0; i + 2 < nbits; i++)
      if (stream[i +: 3] == 3'b110) cnt++;
    return cnt;
  endfunction

  logic [31:0] stream;
  int          nbits;

  // Directed test sequence
  initial begin
    checks  = 0;
    fails   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    pattern = '0;
    pat_len = '0;
    reps    = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset outputs", 32'({busy, valid, data_out, done}), 32'(4'b0000));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single send 110");
    applyStimulus(8'b0000_0110, LW'(3), 4'd0);
    checkFrame("single", 16'h0006, 3, 0, stream, nbits);
    checkOutput("single stream", stream, 32'b110);
    checkOutput("single len", 32'(nbits), 32'd3);
    checkOutput("single det", 32'(count110(stream, nbits)), 32'd1);

    $display("[TB] repeat x3");
    applyStimulus(8'b0000_0110, LW'(3), 4'd2);
    checkFrame("repeat", 16'h0006, 3, 2, stream, nbits);
    checkOutput("repeat stream", stream, 32'b110110110);
    checkOutput("repeat det", 32'(count110(stream, nbits)), 32'd3);

    $display("[TB] zero length request");
    applyStimulus(8'hFF, LW'(0), 4'd1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("zero len idle", 32'({busy, valid, data_out, done}), 32'(4'b0000));
      @(negedge clk);
    end

    $display("[TB] clamped length");
    applyStimulus(8'hA5, LW'(12), 4'd0);
    checkFrame("clamp", 16'h00A5, 8, 0, stream, nbits);
    checkOutput("clamp stream", stream, 32'hA5);
    checkOutput("clamp len", 32'(nbits), 32'd8);

    $display("[TB] start while busy");
    applyStimulus(8'b0000_0110, LW'(3), 4'd1);
    pattern = 8'hFF;
    pat_len = LW'(5);
    reps    = 4'd3;
    start   = 1'b1;
    checkFrame("busy start", 16'h0006, 3, 1, stream, nbits);
    start   = 1'b0;
    checkOutput("busy start stream", stream, 32'b110110);
    @(negedge clk);
    checkOutput("busy start no requeue", 32'({busy, valid, data_out, done}), 32'(4'b0000));

    $display("[TB] reset mid-frame");
    applyStimulus(8'b0000_0110, LW'(3), 4'd0);
    checkOutput("abort bit0", 32'({busy, valid, data_out, done}), 32'(4'b1110));
    @(negedge clk);
    checkOutput("abort bit1", 32'({busy, valid, data_out, done}), 32'(4'b1110));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort cleared", 32'({busy, valid, data_out, done}), 32'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort no done", 32'({busy, valid, data_out, done}), 32'(4'b0000));
    end
    applyStimulus(8'b0000_0110, LW'(3), 4'd0);
    checkFrame("after abort", 16'h0006, 3, 0, stream, nbits);
    checkOutput("after abort stream", stream, 32'b110);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
